// File: rtl/dmem_resp.sv
// -----------------------------------------------------------------------------
// dmem_resp
//
// Data-side memory responder. It sits at the slave end of the execute stage's
// load/store request port. It holds a word-organised data RAM and a small MMIO
// block: a 64-bit machine timer (mtime / mtimecmp) that drives a timer
// interrupt, and a tohost register used to end simulation.
//
// Request semantics: the port has a valid but no ready. The slave accepts
// every request in the cycle where adr_v_i is high. A load is answered
// combinationally in that same cycle. A store commits at the next rising
// edge. A request that is not legal raises access_fault_o in that cycle,
// returns zero data and changes no state. Only one request can be in flight
// per cycle, so a load and a store never share a cycle.
//
// Ports:
//   clk             clock; all state updates on the rising edge
//   reset           synchronous reset, active-high
//   adr_v_i         request valid
//   adr_i           byte address
//   is_store_i      1 = store, 0 = load
//   store_data_i    store data, right-aligned (not yet shifted to its lane)
//   access_size_i   one-hot size: 3'b001 byte, 3'b010 half, 3'b100 word
//   load_data_o     aligned word that holds the addressed bytes; 0 when idle,
//                   on a store, or on a fault
//   access_fault_o  request rejected this cycle
//   timer_irq_o     registered (mtime >= mtimecmp)
//   halt_o          sticky; set by a nonzero store to tohost
//   tohost_o        last value stored to tohost
//
// MMIO map, word access only, offsets from MMIO_BASE:
//   +0x00 mtime[31:0]     +0x04 mtime[63:32]
//   +0x08 mtimecmp[31:0]  +0x0C mtimecmp[63:32]
//   +0x10 tohost          +0x14..+0x1C read as zero; writes are ignored
//
// The datapath assumes XLEN == 32: four byte lanes, and the 64-bit timer
// registers are split into two halves of one word each.
// -----------------------------------------------------------------------------
module dmem_resp #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [XLEN-1:0] RAM_BASE    = 32'h0000_0000,
    parameter logic [XLEN-1:0] MMIO_BASE   = 32'h4000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            adr_v_i,
    input  logic [XLEN-1:0] adr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [2:0]      access_size_i,
    output logic [XLEN-1:0] load_data_o,
    output logic            access_fault_o,
    output logic            timer_irq_o,
    output logic            halt_o,
    output logic [XLEN-1:0] tohost_o
);

    localparam int              AW         = $clog2(DEPTH_WORDS);
    localparam logic [XLEN-1:0] RAM_BYTES  = XLEN'(4 * DEPTH_WORDS);
    localparam logic [XLEN-1:0] MMIO_BYTES = XLEN'(32);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Subtracting the base and comparing the offset against the window size
    // gives one unsigned compare per window. Addresses below the base wrap
    // to large offsets, so they miss as well.
    logic [XLEN-1:0] ram_off;
    logic [XLEN-1:0] mmio_off;
    logic            ram_hit;
    logic            mmio_hit;
    logic [AW-1:0]   ram_idx;
    logic [2:0]      mmio_sel;

    assign ram_off  = adr_i - RAM_BASE;
    assign mmio_off = adr_i - MMIO_BASE;
    assign ram_hit  = (ram_off < RAM_BYTES);
    assign mmio_hit = (mmio_off < MMIO_BYTES);
    assign ram_idx  = ram_off[AW+1:2];
    assign mmio_sel = mmio_off[4:2];

    logic size_b;
    logic size_h;
    logic size_w;
    logic size_ok;
    logic misaligned;
    logic bad_req;
    logic req_ok;

    assign size_b     = (access_size_i == 3'b001);
    assign size_h     = (access_size_i == 3'b010);
    assign size_w     = (access_size_i == 3'b100);
    assign size_ok    = size_b | size_h | size_w;
    assign misaligned = (size_h & adr_i[0]) | (size_w & (adr_i[1:0] != 2'b00));

    // Request-level legality, without adr_v_i. MMIO accepts only word
    // accesses.
    assign bad_req = ~(ram_hit | mmio_hit) | ~size_ok | misaligned
                   | (mmio_hit & ~size_w);

    assign access_fault_o = adr_v_i & bad_req;
    assign req_ok         = adr_v_i & ~bad_req;

    // ------------------------------------------------------------------
    // Store lane steering
    // ------------------------------------------------------------------
    logic [3:0]      byte_en;
    logic [XLEN-1:0] wdata;

    always_comb begin
        byte_en = 4'b0000;
        if (size_b) begin
            byte_en = 4'b0001 << adr_i[1:0];
        end else if (size_h) begin
            byte_en = adr_i[1] ? 4'b1100 : 4'b0011;
        end else if (size_w) begin
            byte_en = 4'b1111;
        end
    end

    assign wdata = store_data_i << {adr_i[1:0], 3'b000};

    // ------------------------------------------------------------------
    // Data RAM (not reset). A store issued while reset is high is dropped.
    // The read port is combinational, so a load in the cycle of a store
    // would still see the old word.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic            ram_we;

    assign ram_we = req_ok & is_store_i & ram_hit & ~reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // MMIO registers
    // ------------------------------------------------------------------
    logic [63:0]     mtime_q;
    logic [63:0]     mtimecmp_q;
    logic            timer_irq_q;
    logic            halt_q;
    logic [XLEN-1:0] tohost_q;

    logic mmio_we;
    logic wr_mtime_lo;
    logic wr_mtime_hi;
    logic wr_cmp_lo;
    logic wr_cmp_hi;
    logic wr_tohost;

    // The RAM and MMIO windows must not overlap, so RAM takes priority here.
    assign mmio_we     = req_ok & is_store_i & mmio_hit & ~ram_hit;
    assign wr_mtime_lo = mmio_we & (mmio_sel == 3'd0);
    assign wr_mtime_hi = mmio_we & (mmio_sel == 3'd1);
    assign wr_cmp_lo   = mmio_we & (mmio_sel == 3'd2);
    assign wr_cmp_hi   = mmio_we & (mmio_sel == 3'd3);
    assign wr_tohost   = mmio_we & (mmio_sel == 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_irq_q <= 1'b0;
            halt_q      <= 1'b0;
            tohost_q    <= '0;
        end else begin
            // A write to either half replaces the increment for that cycle.
            // The other half holds.
            if (wr_mtime_lo) begin
                mtime_q[31:0] <= store_data_i;
            end else if (wr_mtime_hi) begin
                mtime_q[63:32] <= store_data_i;
            end else begin
                mtime_q <= mtime_q + 64'd1;
            end

            if (wr_cmp_lo) begin
                mtimecmp_q[31:0] <= store_data_i;
            end
            if (wr_cmp_hi) begin
                mtimecmp_q[63:32] <= store_data_i;
            end

            if (wr_tohost) begin
                tohost_q <= store_data_i;
                if (store_data_i != '0) begin
                    halt_q <= 1'b1;
                end
            end

            // Compares the current register values, so the irq lags them
            // by one cycle.
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mmio_rdata;

    always_comb begin
        mmio_rdata = '0;
        case (mmio_sel)
            3'd0:    mmio_rdata = mtime_q[31:0];
            3'd1:    mmio_rdata = mtime_q[63:32];
            3'd2:    mmio_rdata = mtimecmp_q[31:0];
            3'd3:    mmio_rdata = mtimecmp_q[63:32];
            3'd4:    mmio_rdata = tohost_q;
            default: mmio_rdata = '0;
        endcase
    end

    always_comb begin
        load_data_o = '0;
        if (req_ok & ~is_store_i) begin
            load_data_o = ram_hit ? mem[ram_idx] : mmio_rdata;
        end
    end

    assign timer_irq_o = timer_irq_q;
    assign halt_o      = halt_q;
    assign tohost_o    = tohost_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

    localparam logic [31:0] MMIO   = 32'h4000_0000;
    localparam logic [31:0] TOHOST = 32'h4000_0010;
    localparam logic [2:0]  SZ_B   = 3'b001;
    localparam logic [2:0]  SZ_H   = 3'b010;
    localparam logic [2:0]  SZ_W   = 3'b100;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        adr_v;
    logic [31:0] adr;
    logic        is_store;
    logic [31:0] store_data;
    logic [2:0]  access_size;
    logic [31:0] load_data;
    logic        access_fault;
    logic        timer_irq;
    logic        halt;
    logic [31:0] tohost;

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    dmem_resp dut (
        .clk            (clk),
        .reset          (reset),
        .adr_v_i        (adr_v),
        .adr_i          (adr),
        .is_store_i     (is_store),
        .store_data_i   (store_data),
        .access_size_i  (access_size),
        .load_data_o    (load_data),
        .access_fault_o (access_fault),
        .timer_irq_o    (timer_irq),
        .halt_o         (halt),
        .tohost_o       (tohost)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        adr_v = 1'b0; is_store = 1'b0; adr = 32'h0; store_data = 32'h0; access_size = SZ_W;
    endtask

    task automatic next_cycle();
        drive_idle();
        @(posedge clk); #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        adr_v = 1'b1; is_store = 1'b1; adr = a; store_data = d; access_size = sz;
        @(posedge clk); #1;
        drive_idle();
    endtask

    // Drives a load and settles the combinational response; caller checks.
    task automatic set_load(input logic [31:0] a, input logic [2:0] sz);
        adr_v = 1'b1; is_store = 1'b0; adr = a; store_data = 32'h0; access_size = sz;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
        checks++; if (tohost !== 32'h0) begin errors++; $display("FAIL reset_tohost: got %h expected 0", tohost); end
        set_load(MMIO + 32'h0, SZ_W);
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL reset_mtime_lo: got %h expected 00000000", load_data); end
        set_load(MMIO + 32'hC, SZ_W);
        checks++; if (load_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h expected ffffffff", load_data); end
        drive_idle();
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_ram_word();
        do_store(32'h100, 32'hDEAD_BEEF, SZ_W);
        set_load(32'h100, SZ_W);
        checks++; if (load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load: got %h expected deadbeef", load_data); end
        checks++; if (access_fault !== 1'b0) begin errors++; $display("FAIL word_fault: got %b expected 0", access_fault); end
        next_cycle();
    endtask

    task automatic test_ram_lanes();
        do_store(32'h100, 32'h1122_3344, SZ_W);
        do_store(32'h103, 32'h0000_00AA, SZ_B);
        set_load(32'h100, SZ_W);
        checks++; if (load_data !== 32'hAA22_3344) begin errors++; $display("FAIL byte_lane3: got %h expected aa223344", load_data); end
        do_store(32'h102, 32'h0000_5566, SZ_H);
        set_load(32'h100, SZ_W);
        checks++; if (load_data !== 32'h5566_3344) begin errors++; $display("FAIL half_upper: got %h expected 55663344", load_data); end
        // Upper bits of right-aligned data must not leak into other lanes.
        do_store(32'h101, 32'hFFFF_FF77, SZ_B);
        set_load(32'h100, SZ_W);
        checks++; if (load_data !== 32'h5566_7744) begin errors++; $display("FAIL byte_lane1: got %h expected 55667744", load_data); end
        do_store(32'h100, 32'hABCD_9988, SZ_H);
        set_load(32'h100, SZ_W);
        checks++; if (load_data !== 32'h5566_9988) begin errors++; $display("FAIL half_lower: got %h expected 55669988", load_data); end
        next_cycle();
    endtask

    task automatic test_faults();
        logic [31:0] f_adr [6];
        logic [2:0]  f_sz  [6];
        f_adr[0] = 32'h102;       f_sz[0] = SZ_W;
        f_adr[1] = 32'h101;       f_sz[1] = SZ_H;
        f_adr[2] = 32'h8000_0000; f_sz[2] = SZ_W;
        f_adr[3] = 32'h100;       f_sz[3] = 3'b011;
        f_adr[4] = 32'h4000;      f_sz[4] = SZ_W;
        f_adr[5] = MMIO + 32'h20; f_sz[5] = SZ_W;
        do_store(32'h104, 32'h0BAD_F00D, SZ_W);
        do_store(32'h3FFC, 32'h7777_1234, SZ_W);
        for (int i = 0; i < 6; i++) begin
            set_load(f_adr[i], f_sz[i]);
            checks++; if (access_fault !== 1'b1) begin errors++; $display("FAIL fault_flag[%0d]: got %b expected 1", i, access_fault); end
            checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL fault_data[%0d]: got %h expected 0", i, load_data); end
        end
        set_load(32'h3FFC, SZ_W);
        checks++; if (access_fault !== 1'b0 || load_data !== 32'h7777_1234) begin errors++; $display("FAIL ram_top: got %b/%h expected 0/77771234", access_fault, load_data); end
        set_load(MMIO + 32'h14, SZ_W);
        checks++; if (access_fault !== 1'b0 || load_data !== 32'h0) begin errors++; $display("FAIL mmio_reserved: got %b/%h expected 0/0", access_fault, load_data); end
        drive_idle();
        adr = 32'h8000_0000; #1;
        checks++; if (access_fault !== 1'b0 || load_data !== 32'h0) begin errors++; $display("FAIL idle_outputs: got %b/%h expected 0/0", access_fault, load_data); end
        next_cycle();
        // Misaligned word store must not touch the word at 0x104.
        adr_v = 1'b1; is_store = 1'b1; adr = 32'h106; store_data = 32'h5555_5555; access_size = SZ_W;
        #1;
        checks++; if (access_fault !== 1'b1) begin errors++; $display("FAIL store_misalign_flag: got %b expected 1", access_fault); end
        next_cycle();
        set_load(32'h104, SZ_W);
        checks++; if (load_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL store_misalign_ram: got %h expected 0badf00d", load_data); end
        // Half-size store to mtimecmp is rejected and leaves it at its reset value.
        adr_v = 1'b1; is_store = 1'b1; adr = MMIO + 32'h8; store_data = 32'h0000_0001; access_size = SZ_H;
        #1;
        checks++; if (access_fault !== 1'b1) begin errors++; $display("FAIL mmio_half_flag: got %b expected 1", access_fault); end
        next_cycle();
        set_load(MMIO + 32'h8, SZ_W);
        checks++; if (load_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mmio_half_cmp: got %h expected ffffffff", load_data); end
        next_cycle();
    endtask

    task automatic test_timer();
        logic [63:0] mt;
        logic        exp_irq;
        reset = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        reset = 1'b0;
        mt = 64'd0;
        do_store(MMIO + 32'h8, 32'd10, SZ_W); mt = mt + 1;
        do_store(MMIO + 32'hC, 32'd0, SZ_W);  mt = mt + 1;
        for (int k = 0; k < 12; k++) begin
            set_load(MMIO + 32'h0, SZ_W);
            checks++; if (load_data !== mt[31:0]) begin errors++; $display("FAIL mtime_count[%0d]: got %h expected %h", k, load_data, mt[31:0]); end
            exp_irq = ((mt - 64'd1) >= 64'd10);
            checks++; if (timer_irq !== exp_irq) begin errors++; $display("FAIL irq_rise[%0d]: got %b expected %b", k, timer_irq, exp_irq); end
            next_cycle();
            mt = mt + 1;
        end
        // Writing the high half holds the low half for that cycle.
        do_store(MMIO + 32'h4, 32'hFFFF_FFFF, SZ_W);
        set_load(MMIO + 32'h0, SZ_W);
        checks++; if (load_data !== mt[31:0]) begin errors++; $display("FAIL mtime_hold: got %h expected %h", load_data, mt[31:0]); end
        do_store(MMIO + 32'h0, 32'hFFFF_FFFE, SZ_W);
        set_load(MMIO + 32'h0, SZ_W);
        checks++; if (load_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mtime_lo_wr: got %h expected fffffffe", load_data); end
        set_load(MMIO + 32'h4, SZ_W);
        checks++; if (load_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtime_hi_wr: got %h expected ffffffff", load_data); end
        next_cycle();
        set_load(MMIO + 32'h0, SZ_W);
        checks++; if (load_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mtime_max: got %h expected ffffffff", load_data); end
        next_cycle();
        set_load(MMIO + 32'h0, SZ_W);
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL wrap_lo: got %h expected 0", load_data); end
        set_load(MMIO + 32'h4, SZ_W);
        checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL wrap_hi: got %h expected 0", load_data); end
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_before_wrap: got %b expected 1", timer_irq); end
        next_cycle();
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_after_wrap: got %b expected 0", timer_irq); end
    endtask

    task automatic test_tohost();
        do_store(TOHOST, 32'h0, SZ_W);
        checks++; if (halt !== 1'b0 || tohost !== 32'h0) begin errors++; $display("FAIL tohost_zero: got %b/%h expected 0/0", halt, tohost); end
        adr_v = 1'b1; is_store = 1'b1; adr = TOHOST; store_data = 32'h1; access_size = SZ_W;
        #1;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_early: got %b expected 0", halt); end
        @(posedge clk); #1;
        drive_idle();
        checks++; if (halt !== 1'b1 || tohost !== 32'h1) begin errors++; $display("FAIL tohost_one: got %b/%h expected 1/1", halt, tohost); end
        do_store(TOHOST, 32'h0, SZ_W);
        checks++; if (halt !== 1'b1 || tohost !== 32'h0) begin errors++; $display("FAIL halt_sticky: got %b/%h expected 1/0", halt, tohost); end
        do_store(TOHOST, 32'hC0DE_0042, SZ_W);
        set_load(TOHOST, SZ_W);
        checks++; if (load_data !== 32'hC0DE_0042) begin errors++; $display("FAIL tohost_read: got %h expected c0de0042", load_data); end
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (halt !== 1'b0 || tohost !== 32'h0) begin errors++; $display("FAIL halt_reset: got %b/%h expected 0/0", halt, tohost); end
        next_cycle();
    endtask

    task automatic test_reset_store();
        do_store(32'h200, 32'h1234_5678, SZ_W);
        reset = 1'b1;
        do_store(32'h200, 32'hCAFE_BABE, SZ_W);
        reset = 1'b0;
        set_load(32'h200, SZ_W);
        checks++; if (load_data !== 32'h1234_5678) begin errors++; $display("FAIL reset_store_ram: got %h expected 12345678", load_data); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 8; i++) begin
            d = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            do_store(32'h300 + 32'(4 * i), d, SZ_W);
            exp_q.push_back(d);
        end
        for (int i = 0; i < 8; i++) begin
            set_load(32'h300 + 32'(4 * i), SZ_W);
            exp = exp_q.pop_front();
            checks++; if (load_data !== exp) begin errors++; $display("FAIL b2b_load[%0d]: got %h expected %h", i, load_data, exp); end
            next_cycle();
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_ram_word();
        test_ram_lanes();
        test_faults();
        test_timer();
        test_tohost();
        test_reset_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
